// File: rtl/data_port_arbiter_pkg.sv
// Shared definitions for the data-port arbiter and its neighbours (memory,
// pipeline MEM stage, loader).
package data_port_arbiter_pkg;

  // Default widths of the memory data port; the pipeline and the memory
  // use the same values.
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  // Last grantee of the data port. IDLE only exists between reset and the
  // first grant, and is treated as "CPU goes first" under contention.
  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_LD   = 2'd2
  } owner_e;

  // One grant bit per requester. At most one bit is ever set.
  typedef struct packed {
    logic cpu;
    logic ld;
  } gnt_t;

endpackage : data_port_arbiter_pkg

// File: rtl/data_port_arbiter_rr_hold_arb.sv
// Two-requester round-robin arbiter with a loader lock and a starvation
// guard. Holds the owner register and the saturating hold counter; the
// grant itself is combinational from the requests and this state.
module rr_hold_arb
  import data_port_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_req,
  input  logic             ld_req,
  input  logic             ld_lock,
  output logic             cpu_gnt,
  output logic             ld_gnt,
  output owner_e           dbg_owner,
  output logic [CNT_W-1:0] dbg_hold_cnt
);

  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);

  owner_e           owner_q;
  owner_e           owner_d;
  logic [CNT_W-1:0] hold_cnt_q;
  logic [CNT_W-1:0] hold_cnt_d;
  gnt_t             gnt;
  logic             hold_spent;

  // A locked loader has used up its contended-grant budget.
  assign hold_spent = (hold_cnt_q >= HOLD_LIMIT);

  // Owner and hold counter registers; reset returns to IDLE with no history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q    <= OWN_IDLE;
      hold_cnt_q <= '0;
    end else begin
      owner_q    <= owner_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Grant selection and next owner/hold counter.
  always_comb begin
    gnt        = '0;
    owner_d    = owner_q;
    hold_cnt_d = hold_cnt_q;

    // Grants are suppressed while reset is asserted so the memory port
    // stays quiet even if requesters keep asserting req.
    if (rst) begin
      if (cpu_req && !ld_req) begin
        gnt.cpu = 1'b1;
      end else if (ld_req && !cpu_req) begin
        gnt.ld = 1'b1;
      end else if (cpu_req && ld_req) begin
        if (owner_q == OWN_LD && ld_lock) begin
          // Locked loader keeps the port until its budget runs out,
          // then the CPU is forced in once.
          if (!hold_spent) begin
            gnt.ld = 1'b1;
          end else begin
            gnt.cpu = 1'b1;
          end
        end else if (owner_q == OWN_CPU) begin
          gnt.ld = 1'b1;
        end else begin
          // Owner LD without lock, or IDLE: CPU goes next.
          gnt.cpu = 1'b1;
        end
      end
    end

    if (gnt.cpu) begin
      owner_d    = OWN_CPU;
      hold_cnt_d = '0;
    end else if (gnt.ld) begin
      owner_d = OWN_LD;
      if (!cpu_req) begin
        hold_cnt_d = '0;
      end else if (hold_cnt_q != '1) begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
    end
  end

  assign cpu_gnt      = gnt.cpu;
  assign ld_gnt       = gnt.ld;
  assign dbg_owner    = owner_q;
  assign dbg_hold_cnt = hold_cnt_q;

endmodule : rr_hold_arb

// File: rtl/data_port_arbiter.sv
// Shares the single data port of the von Neumann memory between the
// pipeline MEM stage (CPU) and the program/debug loader (LD).
//
// Handshake: a requester raises req with we/addr/wdata and holds all of
// them stable until it sees gnt=1 in the same cycle; that cycle is the
// transfer. Writes complete in the grant cycle with no response. Reads
// return exactly one cycle later as a single-cycle rvalid pulse with rdata;
// rvalid cannot be back-pressured. rdata is 0 whenever rvalid is 0.
module data_port_arbiter
  import data_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  // CPU (MEM stage) side
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  // Loader side
  input  logic              ld_req,
  input  logic              ld_lock,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  // Memory data port
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wen,
  input  logic [DATA_W-1:0] mem_rdata
);

  owner_e           arb_owner;
  logic [CNT_W-1:0] arb_hold_cnt;

  logic rd_pend_cpu_q;
  logic rd_pend_cpu_d;
  logic rd_pend_ld_q;
  logic rd_pend_ld_d;

  rr_hold_arb #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) u_arb (
    .clk          (clk),
    .rst          (rst),
    .cpu_req      (cpu_req),
    .ld_req       (ld_req),
    .ld_lock      (ld_lock),
    .cpu_gnt      (cpu_gnt),
    .ld_gnt       (ld_gnt),
    .dbg_owner    (arb_owner),
    .dbg_hold_cnt (arb_hold_cnt)
  );

  // Memory port mux and read-pending tracking; quiet when nobody is granted.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wen   = 1'b0;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_wen   = cpu_we;
    end else if (ld_gnt) begin
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
      mem_wen   = ld_we;
    end
    rd_pend_cpu_d = cpu_gnt & ~cpu_we;
    rd_pend_ld_d  = ld_gnt & ~ld_we;
  end

  // Read-pending flags mark the cycle the memory's registered read data
  // belongs to each requester. Reset drops any read in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pend_cpu_q <= 1'b0;
      rd_pend_ld_q  <= 1'b0;
    end else begin
      rd_pend_cpu_q <= rd_pend_cpu_d;
      rd_pend_ld_q  <= rd_pend_ld_d;
    end
  end

  assign cpu_rvalid = rd_pend_cpu_q;
  assign ld_rvalid  = rd_pend_ld_q;
  assign cpu_rdata  = rd_pend_cpu_q ? mem_rdata : '0;
  assign ld_rdata   = rd_pend_ld_q  ? mem_rdata : '0;
  assign cpu_stall  = cpu_req & ~cpu_gnt;

  // Structural invariants of the arbiter state.
  a_one_hot_gnt : assert property (@(posedge clk) disable iff (!rst)
    !(cpu_gnt && ld_gnt));
  a_hold_bounded : assert property (@(posedge clk) disable iff (!rst)
    arb_hold_cnt <= CNT_W'(MAX_HOLD));
  a_idle_no_hold : assert property (@(posedge clk) disable iff (!rst)
    (arb_owner != OWN_IDLE) || (arb_hold_cnt == '0));

endmodule : data_port_arbiter
